// File: rtl/coef_loader.sv
// coef_loader: writable coefficient store for the FIR filter.
//
// A load session starts with a one-cycle start pulse. Coefficients then
// stream in over a valid/ready handshake and go into a register array, one
// word per cycle. The read side is the same combinational adr -> data lookup
// that the filter datapath already uses, so coefficients can be replaced at
// run time.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; clears the FSM, counter and storage
//   start     one-cycle pulse; begins a session, or restarts one in progress
//   in_valid  in_data carries a coefficient
//   in_ready  loader accepts a word this cycle; a registered decode of the state
//   in_data   coefficient word
//   busy      a session is in progress
//   done      all LUT_size words of the last session have been written
//   load_cnt  number of words accepted in the current or last session
//   adr       read address
//   data      coefficient at adr; 0 for adr >= LUT_size

// One storage entry. It is written only when we_i is high.
module coef_entry #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    val_q <= '0;
    else if (we_i) val_q <= d_i;
  end

  assign q_o = val_q;

endmodule

module coef_loader #(
  parameter int LUT_size   = 16,
  parameter int data_width = 16,
  parameter int REVERSE    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [data_width-1:0]          in_data,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(LUT_size+1)-1:0]  load_cnt,
  input  logic [$clog2(LUT_size)-1:0]    adr,
  output logic [data_width-1:0]          data
);

  localparam int AW = $clog2(LUT_size);
  // One bit wider than AW when LUT_size is a power of two, so that a
  // complete count of LUT_size can be represented.
  localparam int CW = $clog2(LUT_size+1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                              state_q, state_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic                                rdy_q, busy_q, done_q;
  logic                                wr_en;
  logic [AW-1:0]                       wr_idx;
  logic [LUT_size-1:0]                 we;
  logic [LUT_size-1:0][data_width-1:0] mem;

  // A handshake is a write unless start arrives in the same cycle. In that
  // case the restart wins and the word is dropped.
  assign wr_en = rdy_q & in_valid & ~start;

  // While in LOAD, cnt_q is at most LUT_size-1, so its low AW bits address the
  // next entry.
  assign wr_idx = (REVERSE != 0) ? (AW'(LUT_size-1) - cnt_q[AW-1:0])
                                 : cnt_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (start) begin
          cnt_d = '0;
        end else if (wr_en) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(LUT_size-1)) state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The status outputs are flops loaded from the next state. in_ready
  // therefore never depends combinationally on in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == LOAD);
      busy_q  <= (state_d == LOAD);
      done_q  <= (state_d == DONE);
    end
  end

  for (genvar g = 0; g < LUT_size; g++) begin : g_ent
    assign we[g] = wr_en && (wr_idx == AW'(g));
    coef_entry #(.W(data_width)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (we[g]),
      .d_i   (in_data),
      .q_o   (mem[g])
    );
  end

  // The read port is combinational. A write at an edge shows up on data after
  // that edge. Addresses with no entry behind them (possible when LUT_size is
  // not a power of two) read 0.
  always_comb begin
    data = '0;
    for (int i = 0; i < LUT_size; i++) begin
      if (adr == AW'(i)) data = mem[i];
    end
  end

  assign in_ready = rdy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign load_cnt = cnt_q;

endmodule
